stage_dispatch: RTL and testbench
=================================

// Module: stage_dispatch
// PURPOSE
//  Parametrised stage front-end for the deep-feedback FFT/iFFT/NTT/iNTT pipeline. Accepts one
//  128-bit stream (SS), dispatches beats to NK butterfly kernels (ld) and collects results (sw).
//  Returns results on SM in exact input order with sm_lst aligned. Modes: round-robin, single-kernel, bypass.
// PARAMETERS
//  pDATA_WIDTH  128  beat width (two 64-bit words)
//  pNK          4    number of kernels, >=2, power of two
//  pORD_DEPTH   16   order-FIFO depth = max in-flight beats, power of two
// PORTS
//  clk         in   1            clock
//  rstn        in   1            async active-low reset
//  mode        in   2            00 round-robin, 01 single kernel, 10/11 bypass
//  ksel        in   log2(pNK)    kernel index for mode 01
//  ss_vld/ss_rdy/ss_lst  in/out/in  1   input stream handshake, last-of-packet
//  ss_dat      in   pDATA_WIDTH  input beat
//  sm_vld/sm_rdy/sm_lst  out/in/out 1   output stream handshake, last-of-packet
//  sm_dat      out  pDATA_WIDTH  output beat
//  k_ld_vld    out  pNK          per-kernel load valid
//  k_ld_rdy    in   pNK          per-kernel load ready
//  k_ld_dat    out  pNK*pDATA_WIDTH  load data, kernel i at [i*W +: W]
//  k_sw_vld    in   pNK          per-kernel result valid
//  k_sw_rdy    out  pNK          per-kernel result ready
//  k_sw_d      in   pNK*pDATA_WIDTH  result data, kernel i at [i*W +: W]
//  busy        out  1            packet active or beats in flight
// BEHAVIOUR
//  Reset: sm_vld=0, sm_lst=0, sm_dat=0, busy=0, rr_ptr=0, order FIFO empty, cur_mode=00, pkt_act=0.
//  Mode latch: mode/ksel copied to cur_mode/cur_ksel only when pkt_act=0 AND order FIFO empty AND
//   sm_vld=0; otherwise input is held (ss_rdy=0) until drained. pkt_act set on first accepted beat,
//   cleared on accepted beat with ss_lst=1. Mid-packet mode changes ignored.
//  Dispatch (modes 00/01): target t = rr_ptr (00) or cur_ksel (01). Combinational passthrough:
//   k_ld_vld[t]=ss_vld & ~ord_full & latch_ok; k_ld_dat[t]=ss_dat (other lanes 0);
//   ss_rdy=k_ld_rdy[t] & ~ord_full & latch_ok. On fire: push {t, ss_lst} to order FIFO;
//   mode 00 rr_ptr<=rr_ptr+1 (wraps at pNK). rr_ptr resets to 0 on every mode latch.
//  Collect: head {h, l} of order FIFO. out_ld = ~sm_vld | sm_rdy. k_sw_rdy[h]=ord_nempty & out_ld;
//   others 0. On k_sw_vld[h]&k_sw_rdy[h]: pop, sm_dat<=k_sw_d[h], sm_lst<=l, sm_vld<=1.
//   Results from non-head kernels are back-pressured (order preserved; kernels must be in-order).
//  Bypass (10/11): kernels idle (k_ld_vld=0, k_sw_rdy=0); ss_rdy=out_ld & latch_ok;
//   on fire sm_dat<=ss_dat, sm_lst<=ss_lst, sm_vld<=1. Latency 1 cycle.
//  Output reg: sm_vld cleared when sm_rdy & ~new load; held stable (dat/lst) while sm_vld & ~sm_rdy.
//  Latency (00/01): ss fire -> kernel latency -> sm_vld 1 cycle after sw fire. Full throughput 1 beat/cycle.
//  Full: ord count==pORD_DEPTH -> ss_rdy=0. Simultaneous push+pop when full: push blocked (no bypass).
//   Push+pop same cycle otherwise: count unchanged.
//  Empty: k_sw_rdy all 0. busy = pkt_act | ord_nempty | sm_vld.
//  Async reset mid-operation: all state cleared immediately; in-flight kernel beats are discarded
//   (kernels are reset by the same rstn).
// STRUCTURE
//  Shared package stage_pkg: MODE_RR=2'b00, MODE_ONE=2'b01, MODE_BYP=2'b10; clog2 helper; default widths.
//  Sub-module stage_ord_fifo: sync FIFO, width log2(pNK)+1, depth pORD_DEPTH, count/full/empty, no
//   fall-through. Mux/demux and output register inline in stage_dispatch.
// TESTING
//  1 RR: mode=00, 8 beats 0..7 (lst on 7), kernels echo with latency 3 -> sm 0..7 in order, lst on 7th,
//    k_ld lanes 0,1,2,3,0,1,2,3.
//  2 Reorder: kernel1 latency 1, kernel0 latency 6 -> kernel1 result held (k_sw_rdy[1]=0) until k0 pops;
//    sm order unchanged.
//  3 Full: kernels hold k_sw_vld=0, stream 20 beats -> ss_rdy drops after 16 accepted; release -> all 20 out.
//  4 Single: mode=01,ksel=2, 4 beats -> only k_ld_vld[2] toggles; mode->00 mid-packet ignored until lst+drain.
//  5 Bypass + backpressure: mode=10, sm_rdy random 50% -> sm_dat==ss_dat sequence, stable while stalled.
//  6 Reset mid-packet: rstn low at beat 5 of 8 -> sm_vld=0, busy=0, ss_rdy recovers, rr_ptr=0 next beat.

Source files
------------

// File: rtl/stage_pkg.sv
// Shared definitions for the FFT/NTT stage front-end: operating modes, default sizes,
// and a constant-evaluable log2 helper used for port widths.
package stage_pkg;

  localparam int DEF_DATA_WIDTH = 128;
  localparam int DEF_NK         = 4;
  localparam int DEF_ORD_DEPTH  = 16;

  typedef enum logic [1:0] {
    MODE_RR      = 2'b00,
    MODE_ONE     = 2'b01,
    MODE_BYP     = 2'b10,
    MODE_BYP_ALT = 2'b11
  } mode_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  // Both upper encodings route the stream straight to the output register.
  function automatic logic is_bypass(input mode_e m);
    return m[1];
  endfunction

endpackage

// File: rtl/stage_dispatch_if.sv
// Valid/ready stream with last-of-packet marker, used for both the input (SS) and
// output (SM) sides of the stage front-end.
interface stage_dispatch_if #(
  parameter int W = 128
);
  logic         vld;
  logic         rdy;
  logic         lst;
  logic [W-1:0] dat;

  modport master (output vld, output lst, output dat, input rdy);
  modport slave  (input vld, input lst, input dat, output rdy);
endinterface

// File: rtl/stage_ord_fifo.sv
// Order FIFO: remembers which kernel received each in-flight beat (plus its last flag)
// so results can be collected back in input order.
module stage_ord_fifo import stage_pkg::*; #(
  parameter int pWIDTH = 3,
  parameter int pDEPTH = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic [pWIDTH-1:0] wdat,
  input  logic              pop,
  output logic [pWIDTH-1:0] rdat,
  output logic              full,
  output logic              empty
);
  localparam int AW = clog2(pDEPTH);

  logic [pWIDTH-1:0] mem [pDEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [AW:0]       count;
  logic              do_push, do_pop;

  assign full  = (count == (AW+1)'(pDEPTH));
  assign empty = (count == '0);
  // A full FIFO refuses the push even when a pop frees a slot in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdat    = mem[rptr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push != do_pop) count <= do_push ? count + 1'b1 : count - 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdat;
  end

endmodule

// File: rtl/stage_dispatch.sv
// Stage front-end: spreads the input stream over NK butterfly kernels and reassembles
// their results in input order, or passes the stream straight through in bypass mode.
module stage_dispatch import stage_pkg::*; #(
  parameter int pDATA_WIDTH = DEF_DATA_WIDTH,
  parameter int pNK         = DEF_NK,
  parameter int pORD_DEPTH  = DEF_ORD_DEPTH
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [1:0]                 mode,
  input  logic [clog2(pNK)-1:0]      ksel,
  stage_dispatch_if.slave            ss,
  stage_dispatch_if.master           sm,
  output logic [pNK-1:0]             k_ld_vld,
  input  logic [pNK-1:0]             k_ld_rdy,
  output logic [pNK*pDATA_WIDTH-1:0] k_ld_dat,
  input  logic [pNK-1:0]             k_sw_vld,
  output logic [pNK-1:0]             k_sw_rdy,
  input  logic [pNK*pDATA_WIDTH-1:0] k_sw_d,
  output logic                       busy
);
  localparam int KW = clog2(pNK);
  localparam int OW = KW + 1;

  mode_e                  cur_mode, eff_mode;
  logic [KW-1:0]          cur_ksel, eff_ksel, rr_ptr, tgt, head_k;
  logic                   pkt_act, idle, latch_ok, byp, out_ld, ss_rdy;
  logic                   ss_fire, ld_fire, byp_fire, sw_fire, head_lst;
  logic [OW-1:0]          ord_wdat, ord_rdat;
  logic                   ord_full, ord_empty;
  logic                   sm_vld_q, sm_lst_q;
  logic [pDATA_WIDTH-1:0] sm_dat_q;

  // Only a fully drained stage may take a new mode; the first beat of a packet
  // already sees the freshly latched mode and starts round-robin at kernel 0.
  assign idle     = ~pkt_act & ord_empty & ~sm_vld_q;
  assign latch_ok = pkt_act | idle;
  assign eff_mode = idle ? mode_e'(mode) : cur_mode;
  assign eff_ksel = idle ? ksel : cur_ksel;
  assign byp      = is_bypass(eff_mode);
  assign tgt      = (eff_mode == MODE_ONE) ? eff_ksel : (idle ? '0 : rr_ptr);
  assign out_ld   = ~sm_vld_q | sm.rdy;

  assign ord_wdat           = {tgt, ss.lst};
  assign {head_k, head_lst} = ord_rdat;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    ss_rdy   = 1'b0;
    k_ld_vld = '0;
    k_ld_dat = '0;
    k_sw_rdy = '0;
    if (byp) begin
      ss_rdy = out_ld & latch_ok;
    end else begin
      ss_rdy                                     = k_ld_rdy[tgt] & ~ord_full & latch_ok;
      k_ld_vld[tgt]                              = ss.vld & ~ord_full & latch_ok;
      k_ld_dat[tgt*pDATA_WIDTH +: pDATA_WIDTH]   = ss.dat;
      k_sw_rdy[head_k]                           = ~ord_empty & out_ld;
    end
  end

  assign ss.rdy   = ss_rdy;
  assign ss_fire  = ss.vld & ss_rdy;
  assign ld_fire  = ss_fire & ~byp;
  assign byp_fire = ss_fire & byp;
  assign sw_fire  = k_sw_vld[head_k] & k_sw_rdy[head_k];

  stage_ord_fifo #(
    .pWIDTH (OW),
    .pDEPTH (pORD_DEPTH)
  ) u_ord_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (ld_fire),
    .wdat  (ord_wdat),
    .pop   (sw_fire),
    .rdat  (ord_rdat),
    .full  (ord_full),
    .empty (ord_empty)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur_mode <= MODE_RR;
      cur_ksel <= '0;
      rr_ptr   <= '0;
      pkt_act  <= 1'b0;
      sm_vld_q <= 1'b0;
      sm_lst_q <= 1'b0;
      sm_dat_q <= '0;
    end else begin
      if (idle) begin
        cur_mode <= eff_mode;
        cur_ksel <= eff_ksel;
      end
      if (ld_fire && eff_mode == MODE_RR) rr_ptr <= tgt + 1'b1;
      else if (idle)                      rr_ptr <= '0;
      if (ss_fire) pkt_act <= ~ss.lst;

      // Output register: a new load wins; otherwise hold until the consumer takes it.
      if (sw_fire) begin
        sm_vld_q <= 1'b1;
        sm_dat_q <= k_sw_d[head_k*pDATA_WIDTH +: pDATA_WIDTH];
        sm_lst_q <= head_lst;
      end else if (byp_fire) begin
        sm_vld_q <= 1'b1;
        sm_dat_q <= ss.dat;
        sm_lst_q <= ss.lst;
      end else if (sm.rdy) begin
        sm_vld_q <= 1'b0;
      end
    end
  end

  assign sm.vld = sm_vld_q;
  assign sm.lst = sm_lst_q;
  assign sm.dat = sm_dat_q;
  assign busy   = pkt_act | ~ord_empty | sm_vld_q;

endmodule

// File: tb/tb_stage_dispatch.sv
// Directed bench for stage_dispatch: echo-style kernel models, a scoreboard of expected
// output beats and kernel lanes, and one per-cycle compare process on the falling edge.
`timescale 1ns/1ps
module tb_stage_dispatch;
  import stage_pkg::*;

  localparam int W     = 128;
  localparam int NK    = 4;
  localparam int DEPTH = 16;
  localparam int KB    = 64;

  logic          clk  = 1'b0;
  logic          rstn = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [1:0]    ksel = 2'b00;
  logic [NK-1:0] k_ld_vld, k_ld_rdy, k_sw_vld, k_sw_rdy;
  logic [NK*W-1:0] k_ld_dat, k_sw_d;
  logic          busy;

  stage_dispatch_if #(.W(W)) ss_if ();
  stage_dispatch_if #(.W(W)) sm_if ();

  stage_dispatch #(.pDATA_WIDTH(W), .pNK(NK), .pORD_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .mode     (mode),
    .ksel     (ksel),
    .ss       (ss_if),
    .sm       (sm_if),
    .k_ld_vld (k_ld_vld),
    .k_ld_rdy (k_ld_rdy),
    .k_ld_dat (k_ld_dat),
    .k_sw_vld (k_sw_vld),
    .k_sw_rdy (k_sw_rdy),
    .k_sw_d   (k_sw_d),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_out = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Kernels tag results with their own index so a collect from the wrong lane shows up.
  function automatic logic [W-1:0] kfun(input int k, input logic [W-1:0] d);
    logic [3:0] tag;
    tag = 4'(k + 1);
    return d ^ {32{tag}};
  endfunction

  // ---------------- kernel models: in-order pipes with per-kernel latency ----------------
  logic [W-1:0]  kd   [NK][KB];
  int            kdue [NK][KB];
  int            kwp  [NK];
  int            krp  [NK];
  int            klat [NK];
  logic [NK-1:0] khold;
  int            cyc = 0;
  logic [NK-1:0] ld_s, sw_s;
  logic [NK*W-1:0] ld_dat_s;

  always_comb begin
    k_sw_vld = '0;
    k_sw_d   = '0;
    for (int i = 0; i < NK; i++) begin
      k_sw_vld[i]      = (kwp[i] != krp[i]) && (kdue[i][krp[i] % KB] <= cyc) && !khold[i];
      k_sw_d[i*W +: W] = kfun(i, kd[i][krp[i] % KB]);
    end
  end

  always @(negedge clk) begin
    ld_s     = rstn ? (k_ld_vld & k_ld_rdy) : '0;
    sw_s     = rstn ? (k_sw_vld & k_sw_rdy) : '0;
    ld_dat_s = k_ld_dat;
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    for (int i = 0; i < NK; i++) begin
      if (!rstn) begin
        kwp[i] = 0;
        krp[i] = 0;
      end else begin
        if (sw_s[i]) krp[i]++;
        if (ld_s[i]) begin
          kd[i][kwp[i] % KB]   = ld_dat_s[i*W +: W];
          kdue[i][kwp[i] % KB] = cyc + klat[i] - 1;
          kwp[i]++;
        end
      end
    end
  end

  // ---------------- output consumer ----------------
  logic rand_rdy = 1'b0;
  always @(posedge clk) begin
    #1;
    sm_if.rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- scoreboard and per-cycle compare ----------------
  logic [W-1:0] exp_d [$];
  logic         exp_l [$];
  int           exp_lane [$];
  logic         stall_q = 1'b0;
  logic [W-1:0] stall_d;
  logic         stall_l;
  int           cur_lane;

  always @(negedge clk) begin
    if (!rstn) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("sm_hold_vld", sm_if.vld, 1);
        check("sm_hold_dat", sm_if.dat, stall_d);
        check("sm_hold_lst", sm_if.lst, stall_l);
      end
      if (sm_if.vld && sm_if.rdy) begin
        n_out++;
        if (exp_d.size() == 0) check("sm_unexpected", sm_if.vld, 0);
        else begin
          check("sm_dat", sm_if.dat, exp_d.pop_front());
          check("sm_lst", sm_if.lst, exp_l.pop_front());
        end
      end
      if (ss_if.vld && ss_if.rdy) begin
        if (exp_lane.size() == 0) check("ss_unexpected", ss_if.rdy, 0);
        else begin
          cur_lane = exp_lane.pop_front();
          if (cur_lane < 0) check("k_ld_idle", k_ld_vld, 0);
          else begin
            check("k_ld_lane", k_ld_vld, 1 << cur_lane);
            check("k_ld_dat", k_ld_dat[cur_lane*W +: W], ss_if.dat);
          end
        end
      end
      stall_q = sm_if.vld & ~sm_if.rdy;
      stall_d = sm_if.dat;
      stall_l = sm_if.lst;
    end
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic present(input logic [W-1:0] d, input logic l, input int lane,
                         input logic [W-1:0] ex);
    ss_if.vld = 1'b1;
    ss_if.dat = d;
    ss_if.lst = l;
    exp_lane.push_back(lane);
    exp_d.push_back(ex);
    exp_l.push_back(l);
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    @(negedge clk);
    while (!ss_if.rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ss_accept", ss_if.rdy, 1);
    @(posedge clk);
    #1;
    ss_if.vld = 1'b0;
  endtask

  // Each packet starts on a drained stage, so round-robin lanes restart at 0.
  task automatic send_pkt(input logic [1:0] m, input int ks, input int n,
                          input logic [W-1:0] base, input int chg_at);
    logic [W-1:0] d;
    int lane;
    mode = m;
    ksel = 2'(ks);
    for (int j = 0; j < n; j++) begin
      if (j == chg_at) mode = 2'b00;
      d    = base + W'(j);
      lane = m[1] ? -1 : ((m == 2'b01) ? ks : j % NK);
      present(d, j == n - 1, lane, (lane < 0) ? d : kfun(lane, d));
      wait_accept();
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((busy || exp_d.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_busy", busy, 0);
    check("drain_pending", exp_d.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    exp_d.delete();
    exp_l.delete();
    exp_lane.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [W-1:0] d;
    int o0;
    ss_if.vld = 1'b0;
    ss_if.lst = 1'b0;
    ss_if.dat = '0;
    k_ld_rdy  = '1;
    khold     = '0;
    for (int i = 0; i < NK; i++) klat[i] = 3;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sm_vld", sm_if.vld, 0);
    check("rst_sm_lst", sm_if.lst, 0);
    check("rst_sm_dat", sm_if.dat, 0);
    check("rst_busy", busy, 0);
    check("rst_k_sw_rdy", k_sw_rdy, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_ss_rdy", ss_if.rdy, 1);
    @(posedge clk);
    #1;

    // 1: round-robin, 8 beats, latency 3 everywhere
    o0 = n_out;
    send_pkt(2'b00, 0, 8, 128'h0, -1);
    wait_drain();
    check("rr_out_count", n_out - o0, 8);

    // 2: kernel 1 finishes first but must wait for kernel 0
    klat[0] = 6;
    klat[1] = 1;
    send_pkt(2'b00, 0, 2, 128'h100, -1);
    @(negedge clk);
    check("reorder_sw_vld", k_sw_vld, 4'b0010);
    check("reorder_sw_rdy", k_sw_rdy, 4'b0001);
    wait_drain();
    for (int i = 0; i < NK; i++) klat[i] = 3;

    // 3: kernels stall, order FIFO fills after 16 beats
    khold = '1;
    mode  = 2'b00;
    for (int j = 0; j < 20; j++) begin
      d = 128'h200 + W'(j);
      present(d, j == 19, j % NK, kfun(j % NK, d));
      if (j == 16) begin
        repeat (3) @(negedge clk);
        check("full_ss_rdy", ss_if.rdy, 0);
        check("full_k_ld_vld", k_ld_vld, 0);
        check("full_busy", busy, 1);
        @(posedge clk);
        #1;
        khold = '0;
      end
      wait_accept();
    end
    wait_drain();

    // 4: single kernel 2; mode pin flips to round-robin mid-packet
    send_pkt(2'b01, 2, 4, 128'h300, 2);
    @(negedge clk);
    check("one_drain_ss_rdy", ss_if.rdy, 0);
    check("one_drain_busy", busy, 1);
    @(posedge clk);
    #1;
    send_pkt(2'b00, 0, 4, 128'h310, -1);
    wait_drain();

    // 5: bypass, one-cycle latency, then random output backpressure
    send_pkt(2'b10, 0, 1, 128'hABC, -1);
    @(negedge clk);
    check("byp_lat_vld", sm_if.vld, 1);
    check("byp_lat_dat", sm_if.dat, 128'hABC);
    wait_drain();
    rand_rdy = 1'b1;
    send_pkt(2'b11, 0, 12, 128'h400, -1);
    wait_drain();
    rand_rdy = 1'b0;
    send_pkt(2'b10, 0, 3, 128'h450, -1);
    wait_drain();

    // 6: reset in the middle of an 8-beat packet
    mode = 2'b00;
    for (int j = 0; j < 5; j++) begin
      d = 128'h500 + W'(j);
      present(d, 1'b0, j % NK, kfun(j % NK, d));
      wait_accept();
    end
    check("pre_rst_busy", busy, 1);
    rstn = 1'b0;
    clear_sb();
    #1;
    check("mid_rst_sm_vld", sm_if.vld, 0);
    check("mid_rst_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    check("mid_rst_ss_rdy", ss_if.rdy, 1);
    @(posedge clk);
    #1;
    send_pkt(2'b00, 0, 8, 128'h600, -1);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run still active at %0t, limit 400000", $time);
    $fatal(1);
  end

endmodule
